// File: rtl/load_extract_unit_if.sv
// Load-unit bundle: core load request/response plus the data-memory read port.
// master = core/memory side, slave = load_extract_unit.
interface load_extract_unit_if #(
  parameter int ADDR_W = 32
);
  logic              Ld_Valid;
  logic              Ld_Ready;
  logic [ADDR_W-1:0] Ld_Addr;
  logic [2:0]        Ld_Funct3;
  logic              Mem_Req;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Ack;
  logic [31:0]       Mem_RData;
  logic              Rd_Valid;
  logic [31:0]       Rd_Data;
  logic              Ld_Err;

  modport master (
    output Ld_Valid, Ld_Addr, Ld_Funct3, Mem_Ack, Mem_RData,
    input  Ld_Ready, Mem_Req, Mem_Addr, Rd_Valid, Rd_Data, Ld_Err
  );

  modport slave (
    input  Ld_Valid, Ld_Addr, Ld_Funct3, Mem_Ack, Mem_RData,
    output Ld_Ready, Mem_Req, Mem_Addr, Rd_Valid, Rd_Data, Ld_Err
  );
endinterface

// File: rtl/load_extract_unit.sv
// Load path: word-aligned memory read, byte/half/word extraction with sign/zero extension.
// Optional MISALIGN_TRAP_EN: misaligned LH/LHU/LW return Ld_Err without a memory access.
module load_extract_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 RST,
  load_extract_unit_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [1:0]        lane_q;
  logic [2:0]        f3_q;
  logic              rd_vld_q;
  logic [31:0]       rd_data_q;
  logic              ld_err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic        f3_legal;
  logic        misalign;
  logic        timeout_hit;
  logic [31:0] shifted;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  always_comb begin
    f3_legal = 1'b0;
    case (bus.Ld_Funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = (((bus.Ld_Funct3 == 3'b001) || (bus.Ld_Funct3 == 3'b101)) && bus.Ld_Addr[0])
                  || ((bus.Ld_Funct3 == 3'b010) && (bus.Ld_Addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Final allowed Mem_Req cycle; an ack in this same cycle still takes priority.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    shifted  = bus.Mem_RData >> {lane_q, 3'b000};
    half_sel = lane_q[1] ? bus.Mem_RData[31:16] : bus.Mem_RData[15:0];
    case (f3_q)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext_data = {24'h0, shifted[7:0]};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'h0, half_sel};
      default: ext_data = bus.Mem_RData;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      lane_q     <= 2'b00;
      f3_q       <= 3'b000;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= 32'h0;
      ld_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_vld_q <= 1'b0;
          if (bus.Ld_Valid) begin
            mem_addr_q <= {bus.Ld_Addr[ADDR_W-1:2], 2'b00};
            lane_q     <= bus.Ld_Addr[1:0];
            f3_q       <= bus.Ld_Funct3;
            cnt_q      <= '0;
            if (!f3_legal || misalign) begin
              state_q   <= RESP;
              rd_vld_q  <= 1'b1;
              rd_data_q <= 32'h0;
              ld_err_q  <= 1'b1;
            end else begin
              state_q   <= MEM;
              mem_req_q <= 1'b1;
            end
          end
        end
        MEM: begin
          if (bus.Mem_Ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            rd_vld_q  <= 1'b1;
            rd_data_q <= ext_data;
            ld_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            rd_vld_q  <= 1'b1;
            rd_data_q <= 32'h0;
            ld_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          rd_vld_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          rd_vld_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ld_Ready = (state_q == IDLE);
  assign bus.Mem_Req  = mem_req_q;
  assign bus.Mem_Addr = mem_addr_q;
  assign bus.Rd_Valid = rd_vld_q;
  assign bus.Rd_Data  = rd_data_q;
  assign bus.Ld_Err   = ld_err_q;

endmodule

// File: tb/tb_load_extract_unit.sv
// Directed bench for load_extract_unit; expected responses queue up at issue and are
// checked by a monitor whenever Rd_Valid pulses.
module tb_load_extract_unit;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  logic [32:0] sb_q[$];

  load_extract_unit_if #(.ADDR_W(32)) bus ();

  load_extract_unit #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every Rd_Valid cycle must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RST && bus.Rd_Valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("rd_data", bus.Rd_Data, e[31:0]);
        chk("ld_err", {31'h0, bus.Ld_Err}, {31'h0, e[32]});
      end
    end
  end

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                         input int ack_cyc, input bit mem_exp, input logic [31:0] exp_maddr,
                         input int exp_req, input logic [31:0] exp_data, input logic exp_err);
    int reqcyc;
    reqcyc = 0;
    sb_q.push_back({exp_err, exp_data});
    @(negedge CLK);
    chk("ld_ready_idle", {31'h0, bus.Ld_Ready}, 32'd1);
    bus.Ld_Valid  = 1'b1;
    bus.Ld_Addr   = addr;
    bus.Ld_Funct3 = f3;
    @(posedge CLK);
    #1 bus.Ld_Valid = 1'b0;
    if (mem_exp) chk("mem_addr", bus.Mem_Addr, exp_maddr);
    for (int c = 1; c <= 40; c++) begin
      if (bus.Mem_Req !== 1'b1) break;
      reqcyc++;
      if (c == ack_cyc) begin
        bus.Mem_Ack   = 1'b1;
        bus.Mem_RData = rdata;
      end
      @(posedge CLK);
      #1;
      bus.Mem_Ack   = 1'b0;
      bus.Mem_RData = 32'hA5A5_A5A5;
    end
    chk("req_cycles", reqcyc, exp_req);
    chk("rd_valid_pulse", {31'h0, bus.Rd_Valid}, 32'd1);
    chk("mem_req_low_at_resp", {31'h0, bus.Mem_Req}, 32'd0);
    @(posedge CLK);
    #1 chk("rd_valid_single", {31'h0, bus.Rd_Valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Ld_Valid  = 1'b0;
    bus.Ld_Addr   = 32'h0;
    bus.Ld_Funct3 = 3'b000;
    bus.Mem_Ack   = 1'b0;
    bus.Mem_RData = 32'hA5A5_A5A5;

    repeat (2) @(negedge CLK);
    chk("rst_ld_ready", {31'h0, bus.Ld_Ready}, 32'd1);
    chk("rst_mem_req", {31'h0, bus.Mem_Req}, 32'd0);
    chk("rst_mem_addr", bus.Mem_Addr, 32'h0);
    chk("rst_rd_valid", {31'h0, bus.Rd_Valid}, 32'd0);
    chk("rst_rd_data", bus.Rd_Data, 32'h0);
    chk("rst_ld_err", {31'h0, bus.Ld_Err}, 32'd0);
    RST = 1'b0;

    // LB sign-extended, first-cycle ack
    do_load(32'h1003, 3'b000, 32'h8012_3456, 1, 1, 32'h1000, 1, 32'hFFFF_FF80, 1'b0);
    // LHU then LH upper half
    do_load(32'h2002, 3'b101, 32'hBEEF_1234, 1, 1, 32'h2000, 1, 32'h0000_BEEF, 1'b0);
    do_load(32'h2002, 3'b001, 32'hBEEF_1234, 2, 1, 32'h2000, 2, 32'hFFFF_BEEF, 1'b0);
    // LW with ack in third request cycle
    do_load(32'h0010, 3'b010, 32'hDEAD_BEEF, 3, 1, 32'h0010, 3, 32'hDEAD_BEEF, 1'b0);
    // Byte lanes
    do_load(32'h3000, 3'b000, 32'h11F2_7F80, 1, 1, 32'h3000, 1, 32'hFFFF_FF80, 1'b0);
    do_load(32'h3001, 3'b100, 32'h11F2_7F80, 1, 1, 32'h3000, 1, 32'h0000_007F, 1'b0);
    do_load(32'h3002, 3'b000, 32'h11F2_7F80, 1, 1, 32'h3000, 1, 32'hFFFF_FFF2, 1'b0);
    do_load(32'h3003, 3'b100, 32'h11F2_7F80, 1, 1, 32'h3000, 1, 32'h0000_0011, 1'b0);
    do_load(32'h3000, 3'b001, 32'h1234_8001, 1, 1, 32'h3000, 1, 32'hFFFF_8001, 1'b0);
    // Timeout: 15 request cycles then error
    do_load(32'h0040, 3'b010, 32'h0, 0, 1, 32'h0040, 15, 32'h0, 1'b1);
    // Ack in the final allowed cycle beats the timeout
    do_load(32'h0044, 3'b010, 32'h1357_9BDF, 15, 1, 32'h0044, 15, 32'h1357_9BDF, 1'b0);
    // Illegal funct3 codes
    do_load(32'h0050, 3'b011, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1'b1);
    do_load(32'h0050, 3'b111, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1'b1);

    // Stray ack while idle is ignored
    @(negedge CLK);
    bus.Mem_Ack = 1'b1;
    @(posedge CLK);
    #1 bus.Mem_Ack = 1'b0;
    chk("stray_ack_req", {31'h0, bus.Mem_Req}, 32'd0);
    chk("stray_ack_rdv", {31'h0, bus.Rd_Valid}, 32'd0);

    // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    do_load(32'h0102, 3'b010, 32'hCAFE_F00D, 1, 0, 32'h0, 0, 32'h0, 1'b1);
    do_load(32'h3001, 3'b101, 32'h1234_8001, 1, 0, 32'h0, 0, 32'h0, 1'b1);
`else
    do_load(32'h0102, 3'b010, 32'hCAFE_F00D, 1, 1, 32'h0100, 1, 32'hCAFE_F00D, 1'b0);
    do_load(32'h3001, 3'b101, 32'h1234_8001, 1, 1, 32'h3000, 1, 32'h0000_8001, 1'b0);
`endif

    // Reset while a request is outstanding: no response may follow
    @(negedge CLK);
    bus.Ld_Valid  = 1'b1;
    bus.Ld_Addr   = 32'h0080;
    bus.Ld_Funct3 = 3'b010;
    @(posedge CLK);
    #1 bus.Ld_Valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1 chk("mid_req_high", {31'h0, bus.Mem_Req}, 32'd1);
    RST = 1'b1;
    #1;
    chk("mid_rst_req", {31'h0, bus.Mem_Req}, 32'd0);
    chk("mid_rst_rdv", {31'h0, bus.Rd_Valid}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1 chk("post_rst_ready", {31'h0, bus.Ld_Ready}, 32'd1);
    chk("post_rst_req", {31'h0, bus.Mem_Req}, 32'd0);

    // Unit still works after the aborted load
    do_load(32'h0200, 3'b100, 32'h0000_00FE, 2, 1, 32'h0200, 2, 32'h0000_00FE, 1'b0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
